// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern transmitter and the
// sequence-detector benches that consume its output.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAPW = 2'd2,
        FIN  = 2'd3
    } seq_state_e;

    localparam int SEQ_W  = 8;
    localparam int SEQ_CW = 4;

    // Reference pattern the 101 detector benches look for.
    localparam logic [2:0] SEQ_101 = 3'b101;

    typedef struct packed {
        logic out;
        logic valid;
        logic frame;
        logic busy;
        logic done;
    } seq_flags_t;

endpackage

// File: rtl/seq_down_counter.sv
// Loadable down-counter with a zero flag; it saturates at zero rather than wrapping.
module seq_down_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_next_o,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The next value lets the owner register outputs that depend on the count.
    assign cnt_next_o = cnt_d;
    assign zero_o     = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a pattern on start and sends its lower
// plen bits MSB-first, reps+1 times, with GAP idle cycles between repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int W   = SEQ_W,
    parameter int CW  = SEQ_CW,
    parameter int GAP = 1,
    parameter int LW  = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  pattern,
    input  logic [LW-1:0] plen,
    input  logic [CW-1:0] reps,
    output logic          out,
    output logic          valid,
    output logic          frame,
    output logic          busy,
    output logic          done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;
    localparam logic [LW-1:0] W_LEN = LW'(W);

    seq_state_e    state_q, state_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [CW-1:0] rep_q, rep_d;
    seq_flags_t    flags_q, flags_d;

    logic [LW-1:0] plen_clamped;
    logic          idx_load, idx_dec, idx_zero;
    logic [LW-1:0] idx_load_val, idx_next;
    logic          gap_load, gap_dec, gap_zero;
    logic [GW-1:0] gap_cnt_unused;
    logic [W-1:0]  pat_shifted;

    assign plen_clamped = ((plen == '0) || (plen > W_LEN)) ? W_LEN : plen;

    seq_down_counter #(.WIDTH(LW)) u_idx (
        .clk        (clk),
        .rst        (rst),
        .load_i     (idx_load),
        .load_val_i (idx_load_val),
        .dec_i      (idx_dec),
        .cnt_next_o (idx_next),
        .zero_o     (idx_zero)
    );

    seq_down_counter #(.WIDTH(GW)) u_gap (
        .clk        (clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .cnt_next_o (gap_cnt_unused),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        rep_d        = rep_q;
        idx_load     = 1'b0;
        idx_load_val = len_q - LW'(1);
        idx_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_dec      = 1'b0;

        case (state_q)
            IDLE, FIN: begin
                if (start) begin
                    pat_d        = pattern;
                    len_d        = plen_clamped;
                    rep_d        = reps;
                    idx_load     = 1'b1;
                    idx_load_val = plen_clamped - LW'(1);
                    state_d      = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (!idx_zero) begin
                    idx_dec = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d    = rep_q - CW'(1);
                    idx_load = 1'b1;
                    if (GAP > 0) begin
                        gap_load = 1'b1;
                        state_d  = GAPW;
                    end
                end else begin
                    state_d = FIN;
                end
            end
            GAPW: begin
                if (gap_zero) begin
                    state_d = SEND;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are derived from the next state so they appear as registers.
    always_comb begin
        pat_shifted = pat_d >> idx_next;
        flags_d     = '0;
        case (state_d)
            SEND: begin
                flags_d.out   = pat_shifted[0];
                flags_d.valid = 1'b1;
                flags_d.frame = (idx_next == (len_d - LW'(1)));
                flags_d.busy  = 1'b1;
            end
            GAPW:    flags_d.busy = 1'b1;
            FIN:     flags_d.done = 1'b1;
            default: flags_d      = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            flags_q <= flags_d;
        end
    end

    assign out   = flags_q.out;
    assign valid = flags_q.valid;
    assign frame = flags_q.frame;
    assign busy  = flags_q.busy;
    assign done  = flags_q.done;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: table-driven transfers, hand-written corner cases and
// random stimulus compared cycle by cycle against a queue-based reference model.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] plen;
    logic [3:0] reps;

    logic out1, valid1, frame1, busy1, done1;
    logic out0, valid0, frame0, busy0, done0;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    seq_pattern_tx #(.W(8), .CW(4), .GAP(1)) dut_g1 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .plen(plen), .reps(reps),
        .out(out1), .valid(valid1), .frame(frame1), .busy(busy1), .done(done1)
    );

    seq_pattern_tx #(.W(8), .CW(4), .GAP(0)) dut_g0 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .plen(plen), .reps(reps),
        .out(out0), .valid(valid0), .frame(frame0), .busy(busy0), .done(done0)
    );

    // Reference model per gap setting: a whole transfer is expanded into a queue of
    // expected {out,valid,frame,busy,done} words when it is accepted.
    for (genvar gi = 0; gi < 2; gi++) begin : g_model
        logic [4:0] q[$];
        logic [4:0] cur = '0;
        int len;
        always @(posedge clk) begin
            if (rst) begin
                q.delete();
                cur = '0;
            end else begin
                if (!cur[1] && start) begin
                    q.delete();
                    len = (plen == 0 || plen > 8) ? 8 : int'(plen);
                    for (int r = 0; r <= int'(reps); r++) begin
                        for (int b = len - 1; b >= 0; b--)
                            q.push_back({pattern[b], 1'b1, (b == len - 1), 1'b1, 1'b0});
                        if (r < int'(reps))
                            for (int g = 0; g < gi; g++) q.push_back(5'b00010);
                    end
                    q.push_back(5'b00001);
                end
                cur = (q.size() > 0) ? q.pop_front() : 5'b00000;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            check("mon_gap1", {27'd0, out1, valid1, frame1, busy1, done1}, {27'd0, g_model[1].cur});
            check("mon_gap0", {27'd0, out0, valid0, frame0, busy0, done0}, {27'd0, g_model[0].cur});
        end
    end

    typedef struct {
        logic [7:0]  pattern;
        logic [3:0]  plen;
        logic [3:0]  reps;
        logic [31:0] exp_bits;
        int          exp_nbits;
        int          exp_frames;
        int          exp_busy1;
        int          exp_busy0;
        int          exp_det;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input int i);
        logic [31:0] bits;
        int nb, frames, b1, b0, d1, d0, dcyc, det, ds;
        pattern = vecs[i].pattern;
        plen    = vecs[i].plen;
        reps    = vecs[i].reps;
        start   = 1'b1;
        step();
        start = 1'b0;
        bits = '0; nb = 0; frames = 0; b1 = 0; b0 = 0; d1 = 0; d0 = 0; dcyc = 0; det = 0; ds = 0;
        check($sformatf("v%0d_first_valid_frame", i), {30'd0, valid1, frame1}, 32'd3);
        for (int c = 1; c <= 40; c++) begin
            if (valid1) begin
                bits = {bits[30:0], out1};
                nb++;
            end
            if (frame1) frames++;
            if (busy1) begin
                b1++;
                // Non-overlapping 101 detector fed from the serial line.
                case (ds)
                    0: ds = out1 ? 1 : 0;
                    1: ds = out1 ? 1 : 2;
                    default: begin
                        if (out1) det++;
                        ds = 0;
                    end
                endcase
            end
            if (busy0) b0++;
            if (done1) begin
                d1++;
                if (dcyc == 0) dcyc = c;
            end
            if (done0) d0++;
            step();
        end
        check($sformatf("v%0d_bits", i), bits, vecs[i].exp_bits);
        check($sformatf("v%0d_nbits", i), nb, vecs[i].exp_nbits);
        check($sformatf("v%0d_frames", i), frames, vecs[i].exp_frames);
        check($sformatf("v%0d_busy_gap1", i), b1, vecs[i].exp_busy1);
        check($sformatf("v%0d_busy_gap0", i), b0, vecs[i].exp_busy0);
        check($sformatf("v%0d_done_gap1", i), d1, 1);
        check($sformatf("v%0d_done_gap0", i), d0, 1);
        check($sformatf("v%0d_done_cycle", i), dcyc, vecs[i].exp_busy1 + 1);
        check($sformatf("v%0d_det101", i), det, vecs[i].exp_det);
        $display("vec %0d pattern=%0h plen=%0d reps=%0d bits=%0h busy=%0d det=%0d",
                 i, vecs[i].pattern, vecs[i].plen, vecs[i].reps, bits, b1, det);
    endtask

    initial begin
        int dn;
        vecs[0] = '{8'h05, 4'd3, 4'd0, 32'b101, 3, 1, 3, 3, 1};
        vecs[1] = '{8'hA5, 4'd0, 4'd0, 32'hA5, 8, 1, 8, 8, 2};
        vecs[2] = '{8'hA5, 4'd12, 4'd0, 32'hA5, 8, 1, 8, 8, 2};
        vecs[3] = '{{5'd0, SEQ_101}, 4'd3, 4'd2, 32'h16D, 9, 3, 11, 9, 3};
        vecs[4] = '{8'h01, 4'd1, 4'd15, 32'hFFFF, 16, 16, 31, 16, 8};
        vecs[5] = '{8'h3C, 4'd6, 4'd1, 32'hF3C, 12, 2, 13, 12, 0};

        rst = 1'b1; start = 1'b0; pattern = '0; plen = '0; reps = '0;
        repeat (3) step();
        check("reset_gap1", {27'd0, out1, valid1, frame1, busy1, done1}, 32'd0);
        check("reset_gap0", {27'd0, out0, valid0, frame0, busy0, done0}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(i);

        // Start during a transfer is ignored; start held in FIN chains immediately.
        pattern = 8'hA5; plen = 4'd8; reps = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; pattern = 8'h00; plen = 4'd3; reps = 4'd5;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !done1; c++) step();
        check("ign_done_seen", {31'd0, done1}, 32'd1);
        start = 1'b1; pattern = 8'h81; plen = 4'd8; reps = 4'd0;
        step();
        start = 1'b0;
        check("b2b_first_bit", {27'd0, out1, valid1, frame1, busy1, done1}, 32'b11110);
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done1) dn++;
            step();
        end
        check("b2b_done_count", dn, 1);
        $display("seq back_to_back done_count=%0d", dn);

        // Reset on the 4th bit abandons the transfer; reset beats a simultaneous start.
        pattern = 8'hFF; plen = 4'd8; reps = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("rst_mid_busy", {31'd0, busy1}, 32'd1);
        rst = 1'b1;
        step();
        check("rst_clear_gap1", {27'd0, out1, valid1, frame1, busy1, done1}, 32'd0);
        check("rst_clear_gap0", {27'd0, out0, valid0, frame0, busy0, done0}, 32'd0);
        start = 1'b1; pattern = 8'h0F;
        step();
        check("rst_priority", {30'd0, busy1, busy0}, 32'd0);
        rst = 1'b0; start = 1'b0;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (done1 || done0) dn++;
            step();
        end
        check("rst_no_done", dn, 0);
        $display("seq reset_mid_transfer done_count=%0d", dn);

        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 99) == 0);
            start   = ($urandom_range(0, 3) == 0);
            pattern = 8'($urandom);
            plen    = 4'($urandom_range(0, 15));
            reps    = 4'($urandom_range(0, 3));
            step();
        end
        rst = 1'b0; start = 1'b0;
        repeat (80) step();
        $display("seq random 3000 cycles done");

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
